// File: rtl/rom_8b_pkg.sv
// Shared constants and the fixed content rule for the rom_8b read-only memory.
// Optional parity output is enabled by defining ROM_8B_PARITY_EN.
package rom_8b_pkg;

  localparam int ROM_8B_WIDTH = 8;
  localparam int ROM_8B_DEPTH = 8;

  // Word n is (n+1) * 8'h11 kept to 8 bits; callers resize it to their data width.
  function automatic logic [7:0] init_word(input int n);
    int v;
    v = (n + 1) * 17;
    return 8'(v);
  endfunction

endpackage

// File: rtl/rom_8b_table.sv
// Purely combinational address-to-word lookup for rom_8b.
// Addresses at or beyond DEPTH read as all zeros.
module rom_8b_table
  import rom_8b_pkg::*;
#(
  parameter int WIDTH      = ROM_8B_WIDTH,
  parameter int DEPTH      = ROM_8B_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [WIDTH-1:0]      word
);

  always_comb begin
    word = '0;
    if (int'(address) < DEPTH) begin
      word = WIDTH'(init_word(int'(address)));
    end
  end

endmodule

// File: rtl/rom_8b.sv
// Registered read port for a small fixed-content ROM with a one-cycle read latency.
// Define ROM_8B_PARITY_EN to add a registered even-parity output alongside data_out.
module rom_8b
  import rom_8b_pkg::*;
#(
  parameter int WIDTH      = ROM_8B_WIDTH,
  parameter int DEPTH      = ROM_8B_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chip_sel,
  input  logic                  read_ena,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [WIDTH-1:0]      data_out,
  output logic                  rd_valid
`ifdef ROM_8B_PARITY_EN
  ,
  output logic                  data_parity
`endif
);

  // Read handshake: a read is taken on any rising edge where reset is low and
  // chip_sel and read_ena are both high; rd_valid is high for exactly the next
  // cycle and marks data_out as freshly loaded. There is no back-pressure.
  logic             read_accept;
  logic [WIDTH-1:0] table_word;

  assign read_accept = chip_sel && read_ena;

  rom_8b_table #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_table (
    .address (address),
    .word    (table_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= read_accept;
      if (read_accept) begin
        data_out <= table_word;
      end
    end
  end

`ifdef ROM_8B_PARITY_EN
  // Parity tracks data_out register-for-register so the two never disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_parity <= 1'b0;
    end else if (read_accept) begin
      data_parity <= ^table_word;
    end
  end
`endif

endmodule

// File: tb/tb_rom_8b.sv
// Self-checking bench for rom_8b: a default instance plus a 4-bit, 6-deep
// instance that exercises truncation, out-of-range addresses and odd parity.
module tb_rom_8b;

  logic       clk;
  logic       reset;
  logic       chip_sel;
  logic       read_ena;
  logic [2:0] address;
  logic [7:0] data_out;
  logic       rd_valid;
  logic [3:0] data_out_n;
  logic       rd_valid_n;
`ifdef ROM_8B_PARITY_EN
  logic       data_parity;
  logic       data_parity_n;
`endif

  int checks_total;
  int checks_passed;

  // Reference state, derived from the read rules
  logic [7:0] exp_data;
  logic       exp_valid;
  logic [7:0] exp_data_n;

  rom_8b dut (
    .clk         (clk),
    .reset       (reset),
    .chip_sel    (chip_sel),
    .read_ena    (read_ena),
    .address     (address),
    .data_out    (data_out),
    .rd_valid    (rd_valid)
`ifdef ROM_8B_PARITY_EN
    ,
    .data_parity (data_parity)
`endif
  );

  rom_8b #(
    .WIDTH      (4),
    .DEPTH      (6),
    .ADDR_WIDTH (3)
  ) dut_n (
    .clk         (clk),
    .reset       (reset),
    .chip_sel    (chip_sel),
    .read_ena    (read_ena),
    .address     (address),
    .data_out    (data_out_n),
    .rd_valid    (rd_valid_n)
`ifdef ROM_8B_PARITY_EN
    ,
    .data_parity (data_parity_n)
`endif
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] spec_word(input int width, input int depth, input int n);
    int v;
    if (n >= depth) return 8'h00;
    v = ((n + 1) * 17) % (1 << width);
    return 8'(v);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data_out"}, data_out, exp_data);
    check({tag, ".rd_valid"}, {7'd0, rd_valid}, {7'd0, exp_valid});
    check({tag, ".data_out_n"}, {4'd0, data_out_n}, exp_data_n);
    check({tag, ".rd_valid_n"}, {7'd0, rd_valid_n}, {7'd0, exp_valid});
`ifdef ROM_8B_PARITY_EN
    check({tag, ".parity"}, {7'd0, data_parity}, {7'd0, ^exp_data});
    check({tag, ".parity_n"}, {7'd0, data_parity_n}, {7'd0, ^exp_data_n});
`endif
  endtask

  // Driver: apply inputs, clock one edge, advance the model, check after the edge.
  task automatic step(input logic r, input logic cs, input logic re,
                      input logic [2:0] a, input string tag);
    reset    = r;
    chip_sel = cs;
    read_ena = re;
    address  = a;
    @(posedge clk);
    if (r) begin
      exp_data   = 8'h00;
      exp_data_n = 8'h00;
      exp_valid  = 1'b0;
    end else if (cs && re) begin
      exp_data   = spec_word(8, 8, int'(a));
      exp_data_n = spec_word(4, 6, int'(a));
      exp_valid  = 1'b1;
    end else begin
      exp_valid  = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    exp_data      = 8'h00;
    exp_data_n    = 8'h00;
    exp_valid     = 1'b0;
    reset         = 1'b1;
    chip_sel      = 1'b1;
    read_ena      = 1'b1;
    address       = 3'd3;
    #1;

    // Reset wins over an active read request
    step(1'b1, 1'b1, 1'b1, 3'd3, "reset_c0");
    step(1'b1, 1'b1, 1'b1, 3'd3, "reset_c1");

    // Deselected: no read even with read_ena high
    step(1'b0, 1'b0, 1'b1, 3'd5, "cs_low");

    // Alternate read_ena while walking every address
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 1'b1, 1'b0, 3'(a), "walk_idle");
      step(1'b0, 1'b1, 1'b1, 3'(a), "walk_read");
    end
    step(1'b0, 1'b1, 1'b0, 3'd2, "walk_hold");

    // Back-to-back reads keep rd_valid high
    step(1'b0, 1'b1, 1'b1, 3'd7, "b2b_7");
    step(1'b0, 1'b1, 1'b1, 3'd0, "b2b_0");
    step(1'b0, 1'b1, 1'b0, 3'd4, "b2b_end");

    // Reset discards a read on the same edge; next read is accepted at once
    step(1'b1, 1'b1, 1'b1, 3'd2, "rst_vs_read");
    step(1'b0, 1'b1, 1'b1, 3'd2, "post_reset_read");

    // Address changes with no accepted read leave outputs alone
    step(1'b0, 1'b1, 1'b0, 3'd6, "addr_wiggle0");
    step(1'b0, 1'b0, 1'b0, 3'd1, "addr_wiggle1");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "random");
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
